multicycle_controller: RTL
==========================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state changes on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have inputs opc[6:0], f3[2:0], f7[6:0], zero, sign: instruction fields and ALU flags from datapath.
REQ-004 SHALL have outputs PCwrite, oldPCwrite, IRwrite, memwrite, regwrite, adrsrc (1 bit each): datapath enables/select.
REQ-005 SHALL have outputs IMMsrc[2:0], ALUcontrol[2:0], ALUsrcA[1:0], ALUsrcB[1:0], resultsrc[1:0]: datapath selects.
REQ-006 SHALL have output halted, 1 bit: illegal-opcode stop indicator.

Function
REQ-007 Encodings SHALL be: ALUsrcA 0=PC,1=oldPC,2=A; ALUsrcB 0=B,1=imm,2=const 4; resultsrc 0=ALUreg,1=ALUout,2=MDR,3=imm; adrsrc 0=PC,1=result.
REQ-008 Encodings SHALL be: IMMsrc 0=I,1=S,2=B,3=J,4=U; ALUcontrol 0=add,1=sub,2=and,3=or,4=slt,5=xor.
REQ-009 Outputs SHALL be Moore-decoded from state, plus zero/sign for PCwrite in BRANCH; unlisted signals 0 in every state.
REQ-010 FETCH: adrsrc=0, IRwrite=1, oldPCwrite=1, ALUsrcA=0, ALUsrcB=2, add, resultsrc=1, PCwrite=1 -> DECODE.
REQ-011 DECODE: ALUsrcA=1, ALUsrcB=1, add, IMMsrc=B for branch, J otherwise; next by opc.
REQ-012 Next from DECODE: 0110011->EXEC_R, 0010011->EXEC_I, 0000011/0100011->MEM_ADR, 1100011->BRANCH, 1101111->JAL, 1100111->JALR, 0110111->LUI, other->see REQ-024.
REQ-013 EXEC_R: ALUsrcA=2, ALUsrcB=0, ALUcontrol per REQ-020 -> ALU_WB; EXEC_I: ALUsrcA=2, ALUsrcB=1, IMMsrc=I -> ALU_WB.
REQ-014 ALU_WB: resultsrc=0, regwrite=1 -> FETCH.
REQ-015 MEM_ADR: ALUsrcA=2, ALUsrcB=1, add, IMMsrc=I (lw) or S (sw) -> MEM_READ (lw) / MEM_WRITE (sw).
REQ-016 MEM_READ: adrsrc=1, resultsrc=0 -> MEM_WB; MEM_WB: resultsrc=2, regwrite=1 -> FETCH; MEM_WRITE: adrsrc=1, resultsrc=0, memwrite=1 -> FETCH.
REQ-017 BRANCH: ALUsrcA=2, ALUsrcB=0, sub, resultsrc=0; PCwrite = taken; f3 000 zero, 001 !zero, 100 sign, 101 !sign, other never -> FETCH.
REQ-018 JAL: resultsrc=0, PCwrite=1, ALUsrcA=1, ALUsrcB=2, add -> LINK_WB; LINK_WB: resultsrc=0, regwrite=1 -> FETCH.
REQ-019 JALR: ALUsrcA=2, ALUsrcB=1, IMMsrc=I, add -> JALR_PC; JALR_PC: identical to JAL -> LINK_WB; LUI: IMMsrc=U, resultsrc=3, regwrite=1 -> FETCH.
REQ-020 ALU decode: f3 000 add (sub if R-type and f7[5]=1), 111 and, 110 or, 010 slt, 100 xor, other add.
REQ-021 Cycle counts SHALL be: R/I 4, lw 5, sw 4, branch 3, jal 4, jalr 5, lui 3.

Reset
REQ-022 rst SHALL force state to FETCH and halted to 0 immediately, regardless of clock.
REQ-023 While rst is high, PCwrite, oldPCwrite, IRwrite, memwrite and regwrite SHALL be 0; first FETCH executes on first edge after deassertion; reset mid-instruction abandons it with no further writes.

Configuration
REQ-024 With ILLEGAL_TRAP_EN defined, unknown opcode SHALL go DECODE->HALT; HALT drives all enables 0, halted=1, stays until rst. Without it, unknown opcode SHALL go DECODE->FETCH (3-cycle NOP) and halted is tied 0.

Structure
REQ-025 Shared package SHALL hold state enum, opcode constants, ALUcontrol/IMMsrc codes and mux select codes.
REQ-026 ALU decoding (REQ-020) SHALL be one combinational sub-module alu_decoder; all else in multicycle_controller.

Verification
REQ-027 add (opc 0110011, f3 000, f7 0000000) after reset -> FETCH,DECODE,EXEC_R,ALU_WB; ALUcontrol=0; regwrite=1 only in cycle 4.
REQ-028 sub (f7 0100000) -> ALUcontrol=1 in EXEC_R; andi (0010011, f3 111) -> ALUcontrol=2, ALUsrcB=1.
REQ-029 beq with zero=1 -> PCwrite=1 in BRANCH; beq zero=0 -> PCwrite=0; bge sign=1 -> 0; next state FETCH.
REQ-030 lw -> 5 states, adrsrc=1 in MEM_READ, resultsrc=2 and regwrite=1 in MEM_WB; sw -> memwrite=1 exactly one cycle.
REQ-031 jalr -> JALR, JALR_PC (PCwrite=1, resultsrc=0), LINK_WB (regwrite=1); rst pulsed in JALR_PC -> FETCH, no regwrite.
REQ-032 opc 1111111: with ILLEGAL_TRAP_EN -> halted=1, all enables 0 for 10+ cycles until rst; without -> FETCH after DECODE.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle controller: FSM state codes, opcodes,
// and the ALU, immediate and mux select codes the datapath decodes.
package multicycle_controller_pkg;

   localparam logic [3:0] S_FETCH     = 4'd0;
   localparam logic [3:0] S_DECODE    = 4'd1;
   localparam logic [3:0] S_EXEC_R    = 4'd2;
   localparam logic [3:0] S_EXEC_I    = 4'd3;
   localparam logic [3:0] S_ALU_WB    = 4'd4;
   localparam logic [3:0] S_MEM_ADR   = 4'd5;
   localparam logic [3:0] S_MEM_READ  = 4'd6;
   localparam logic [3:0] S_MEM_WB    = 4'd7;
   localparam logic [3:0] S_MEM_WRITE = 4'd8;
   localparam logic [3:0] S_BRANCH    = 4'd9;
   localparam logic [3:0] S_JAL       = 4'd10;
   localparam logic [3:0] S_LINK_WB   = 4'd11;
   localparam logic [3:0] S_JALR      = 4'd12;
   localparam logic [3:0] S_JALR_PC   = 4'd13;
   localparam logic [3:0] S_LUI       = 4'd14;
   localparam logic [3:0] S_HALT      = 4'd15;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_SLT = 3'd4;
   localparam logic [2:0] ALU_XOR = 3'd5;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_J = 3'd3;
   localparam logic [2:0] IMM_U = 3'd4;

   localparam logic [1:0] SRCA_PC    = 2'd0;
   localparam logic [1:0] SRCA_OLDPC = 2'd1;
   localparam logic [1:0] SRCA_A     = 2'd2;

   localparam logic [1:0] SRCB_B    = 2'd0;
   localparam logic [1:0] SRCB_IMM  = 2'd1;
   localparam logic [1:0] SRCB_FOUR = 2'd2;

   localparam logic [1:0] RES_ALUREG = 2'd0;
   localparam logic [1:0] RES_ALUOUT = 2'd1;
   localparam logic [1:0] RES_MDR    = 2'd2;
   localparam logic [1:0] RES_IMM    = 2'd3;

   localparam logic ADR_PC     = 1'b0;
   localparam logic ADR_RESULT = 1'b1;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU operation decode from funct3/funct7[5]; zero latency.
module alu_decoder
   import multicycle_controller_pkg::*;
(
   input  logic [2:0] f3,
   input  logic       f7_5,
   input  logic       rtype,
   output logic [2:0] alu_ctrl
);

   always_comb begin
      alu_ctrl = ALU_ADD;
      case (f3)
         3'b000:  alu_ctrl = (rtype && f7_5) ? ALU_SUB : ALU_ADD;
         3'b111:  alu_ctrl = ALU_AND;
         3'b110:  alu_ctrl = ALU_OR;
         3'b010:  alu_ctrl = ALU_SLT;
         3'b100:  alu_ctrl = ALU_XOR;
         default: alu_ctrl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-decoded multicycle RV32 control FSM, one state per cycle, no stalls.
// ILLEGAL_TRAP_EN: unknown opcodes park in HALT until reset instead of acting as a NOP.
module multicycle_controller
   import multicycle_controller_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opc,
   input  logic [2:0] f3,
   input  logic [6:0] f7,
   input  logic       zero,
   input  logic       sign,
   output logic       PCwrite,
   output logic       oldPCwrite,
   output logic       IRwrite,
   output logic       memwrite,
   output logic       regwrite,
   output logic       adrsrc,
   output logic [2:0] IMMsrc,
   output logic [2:0] ALUcontrol,
   output logic [1:0] ALUsrcA,
   output logic [1:0] ALUsrcB,
   output logic [1:0] resultsrc,
   output logic       halted
);

   logic [3:0] state_q, state_d;
   logic       pcw, oldpcw, irw, memw, regw;
   logic       taken;
   logic [2:0] alu_dec;
   logic       unused_f7;

   assign unused_f7 = ^{f7[6], f7[4:0]};

   alu_decoder u_alu_dec (
      .f3       (f3),
      .f7_5     (f7[5]),
      .rtype    (opc[5]),
      .alu_ctrl (alu_dec)
   );

   always_comb begin
      case (f3)
         3'b000:  taken = zero;
         3'b001:  taken = ~zero;
         3'b100:  taken = sign;
         3'b101:  taken = ~sign;
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      pcw        = 1'b0;
      oldpcw     = 1'b0;
      irw        = 1'b0;
      memw       = 1'b0;
      regw       = 1'b0;
      adrsrc     = ADR_PC;
      IMMsrc     = IMM_I;
      ALUcontrol = ALU_ADD;
      ALUsrcA    = SRCA_PC;
      ALUsrcB    = SRCB_B;
      resultsrc  = RES_ALUREG;
      case (state_q)
         S_FETCH: begin
            irw       = 1'b1;
            oldpcw    = 1'b1;
            pcw       = 1'b1;
            ALUsrcB   = SRCB_FOUR;
            resultsrc = RES_ALUOUT;
            state_d   = S_DECODE;
         end
         S_DECODE: begin
            ALUsrcA = SRCA_OLDPC;
            ALUsrcB = SRCB_IMM;
            IMMsrc  = (opc == OP_BRANCH) ? IMM_B : IMM_J;
            case (opc)
               OP_R:      state_d = S_EXEC_R;
               OP_I:      state_d = S_EXEC_I;
               OP_LOAD,
               OP_STORE:  state_d = S_MEM_ADR;
               OP_BRANCH: state_d = S_BRANCH;
               OP_JAL:    state_d = S_JAL;
               OP_JALR:   state_d = S_JALR;
               OP_LUI:    state_d = S_LUI;
`ifdef ILLEGAL_TRAP_EN
               default:   state_d = S_HALT;
`else
               default:   state_d = S_FETCH;
`endif
            endcase
         end
         S_EXEC_R: begin
            ALUsrcA    = SRCA_A;
            ALUcontrol = alu_dec;
            state_d    = S_ALU_WB;
         end
         S_EXEC_I: begin
            ALUsrcA    = SRCA_A;
            ALUsrcB    = SRCB_IMM;
            ALUcontrol = alu_dec;
            state_d    = S_ALU_WB;
         end
         S_ALU_WB, S_LINK_WB: begin
            regw    = 1'b1;
            state_d = S_FETCH;
         end
         S_MEM_ADR: begin
            ALUsrcA = SRCA_A;
            ALUsrcB = SRCB_IMM;
            IMMsrc  = opc[5] ? IMM_S : IMM_I;
            state_d = opc[5] ? S_MEM_WRITE : S_MEM_READ;
         end
         S_MEM_READ: begin
            adrsrc  = ADR_RESULT;
            state_d = S_MEM_WB;
         end
         S_MEM_WB: begin
            resultsrc = RES_MDR;
            regw      = 1'b1;
            state_d   = S_FETCH;
         end
         S_MEM_WRITE: begin
            adrsrc  = ADR_RESULT;
            memw    = 1'b1;
            state_d = S_FETCH;
         end
         S_BRANCH: begin
            ALUsrcA    = SRCA_A;
            ALUcontrol = ALU_SUB;
            pcw        = taken;
            state_d    = S_FETCH;
         end
         S_JAL, S_JALR_PC: begin
            pcw     = 1'b1;
            ALUsrcA = SRCA_OLDPC;
            ALUsrcB = SRCB_FOUR;
            state_d = S_LINK_WB;
         end
         S_JALR: begin
            ALUsrcA = SRCA_A;
            ALUsrcB = SRCB_IMM;
            state_d = S_JALR_PC;
         end
         S_LUI: begin
            IMMsrc    = IMM_U;
            resultsrc = RES_IMM;
            regw      = 1'b1;
            state_d   = S_FETCH;
         end
         default: state_d = state_q;
      endcase
   end

   // State is already FETCH during reset; gating keeps its writes from firing early.
   assign PCwrite    = pcw    & ~rst;
   assign oldPCwrite = oldpcw & ~rst;
   assign IRwrite    = irw    & ~rst;
   assign memwrite   = memw   & ~rst;
   assign regwrite   = regw   & ~rst;

`ifdef ILLEGAL_TRAP_EN
   assign halted = (state_q == S_HALT);
`else
   assign halted = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

endmodule
